// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - debug run-control scheduler driving the CPU clock enable
module run_ctrl #(
    parameter int NBRK = 4,
    parameter int IDXW = 2,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            step,
    input  logic            cont,
    input  logic            runn,
    input  logic            halt,
    input  logic [CNTW-1:0] run_n,
    input  logic            brk_wr,
    input  logic            brk_clr,
    input  logic [IDXW-1:0] brk_idx,
    input  logic [31:0]     brk_din,
    input  logic [31:0]     pc,
    output logic            cpu_en,
    output logic            pause,
    output logic [1:0]      mode,
    output logic            brk_hit,
    output logic [IDXW-1:0] brk_hit_idx,
    output logic [31:0]     retired
);

    typedef enum logic [1:0] {
        S_PAUSE = 2'd0,
        S_STEP  = 2'd1,
        S_CONT  = 2'd2,
        S_RUNN  = 2'd3
    } state_t;

    state_t            state_q;
    logic              step_q, cont_q, runn_q;
    logic              first_q;
    logic [CNTW-1:0]   cnt_q;
    logic              brk_hit_q;
    logic [IDXW-1:0]   brk_hit_idx_q;
    logic [31:0]       retired_q, retired_d;
    logic [NBRK-1:0]   valid_q;
    logic [31:0]       addr_q [NBRK];

    logic              req_step, req_cont, req_runn;
    logic              match;
    logic [IDXW-1:0]   hit_idx;

    assign req_step = step & ~step_q;
    assign req_cont = cont & ~cont_q;
    assign req_runn = runn & ~runn_q;

    // Breakpoint compare; scanning downwards lets the lowest matching entry win.
    always_comb begin
        match   = 1'b0;
        hit_idx = '0;
        for (int i = NBRK - 1; i >= 0; i--) begin
            if (valid_q[i] && addr_q[i] == pc) begin
                match   = 1'b1;
                hit_idx = IDXW'(i);
            end
        end
    end

    // A stop request by step in CONT suppresses the pulse of that same cycle.
    assign cpu_en = (state_q != S_PAUSE) & ~halt & ~(match & ~first_q)
                  & ~((state_q == S_CONT) & req_step);

    assign retired_d = retired_q + 32'd1;

    // Button edge detectors and retired-instruction counter.
    always_ff @(posedge clk) begin
        step_q <= step;
        cont_q <= cont;
        runn_q <= runn;
        if (!rstn) begin
            retired_q <= '0;
        end else if (cpu_en) begin
            retired_q <= retired_d;
        end
    end

    // Breakpoint table; only editable while paused, clear beats write.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q <= '0;
            for (int i = 0; i < NBRK; i++) addr_q[i] <= '0;
        end else if (state_q == S_PAUSE) begin
            if (brk_clr) begin
                valid_q[brk_idx] <= 1'b0;
            end else if (brk_wr) begin
                valid_q[brk_idx] <= 1'b1;
                addr_q[brk_idx]  <= brk_din;
            end
        end
    end

    // Run-control FSM with step counter, first flag and sticky breakpoint status.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= S_PAUSE;
            first_q       <= 1'b0;
            cnt_q         <= '0;
            brk_hit_q     <= 1'b0;
            brk_hit_idx_q <= '0;
        end else begin
            if (cpu_en) first_q <= 1'b0;
            case (state_q)
                S_PAUSE: begin
                    if (req_step) begin
                        state_q   <= S_STEP;
                        first_q   <= 1'b1;
                        brk_hit_q <= 1'b0;
                    end else if (req_runn) begin
                        if (run_n != '0) begin
                            state_q   <= S_RUNN;
                            cnt_q     <= run_n;
                            first_q   <= 1'b1;
                            brk_hit_q <= 1'b0;
                        end
                    end else if (req_cont) begin
                        state_q   <= S_CONT;
                        first_q   <= 1'b1;
                        brk_hit_q <= 1'b0;
                    end
                end
                S_STEP: begin
                    state_q <= S_PAUSE;
                end
                S_CONT: begin
                    if (halt) begin
                        state_q <= S_PAUSE;
                    end else if (match && !first_q) begin
                        state_q       <= S_PAUSE;
                        brk_hit_q     <= 1'b1;
                        brk_hit_idx_q <= hit_idx;
                    end else if (req_step) begin
                        state_q <= S_PAUSE;
                    end
                end
                S_RUNN: begin
                    if (halt) begin
                        state_q <= S_PAUSE;
                    end else if (match && !first_q) begin
                        state_q       <= S_PAUSE;
                        brk_hit_q     <= 1'b1;
                        brk_hit_idx_q <= hit_idx;
                    end else if (cpu_en) begin
                        cnt_q <= cnt_q - CNTW'(1);
                        if (cnt_q == CNTW'(1)) state_q <= S_PAUSE;
                    end
                end
                default: state_q <= S_PAUSE;
            endcase
        end
    end

    assign pause       = (state_q == S_PAUSE);
    assign mode        = state_q;
    assign brk_hit     = brk_hit_q;
    assign brk_hit_idx = brk_hit_idx_q;
    assign retired     = retired_q;

endmodule
